// File: rtl/cpu7_csr_irq_if.sv
// rtl/cpu7_csr_irq_if.sv - CSR access, interrupt and exception-event bundle for the cpu7 CSR unit
interface cpu7_csr_irq_if #(
  parameter int GRLEN   = 32,
  parameter int CSR_BIT = 14,
  parameter int NHWI    = 8
);
  logic [CSR_BIT-1:0] csr_raddr;
  logic [GRLEN-1:0]   csr_rdata;
  logic [CSR_BIT-1:0] csr_waddr;
  logic [GRLEN-1:0]   csr_wdata;
  logic               csr_wen;
  logic [NHWI-1:0]    hw_int;
  logic               ecl_csr_int_e;
  logic               ecl_csr_illinst_e;
  logic               ecl_csr_syscall_e;
  logic               ecl_csr_brk_e;
  logic               ecl_csr_ale_e;
  logic [GRLEN-1:0]   ecl_csr_badv_e;
  logic [GRLEN-1:0]   ifu_exu_pc_e;
  logic               ecl_csr_ertn_e;
  logic [GRLEN-1:0]   csr_eentry;
  logic [GRLEN-1:0]   csr_era;
  logic               csr_int_req;

  modport master (
    output csr_raddr, csr_waddr, csr_wdata, csr_wen, hw_int,
    output ecl_csr_int_e, ecl_csr_illinst_e, ecl_csr_syscall_e, ecl_csr_brk_e, ecl_csr_ale_e,
    output ecl_csr_badv_e, ifu_exu_pc_e, ecl_csr_ertn_e,
    input  csr_rdata, csr_eentry, csr_era, csr_int_req
  );

  modport slave (
    input  csr_raddr, csr_waddr, csr_wdata, csr_wen, hw_int,
    input  ecl_csr_int_e, ecl_csr_illinst_e, ecl_csr_syscall_e, ecl_csr_brk_e, ecl_csr_ale_e,
    input  ecl_csr_badv_e, ifu_exu_pc_e, ecl_csr_ertn_e,
    output csr_rdata, csr_eentry, csr_era, csr_int_req
  );
endinterface

// File: rtl/cpu7_csr_irq.sv
// rtl/cpu7_csr_irq.sv - cpu7 CSR unit with interrupts, countdown timer and exception recording
module cpu7_csr_irq #(
  parameter int GRLEN   = 32,
  parameter int CSR_BIT = 14,
  parameter int NHWI    = 8,
  parameter int TIMER_W = 32
) (
  input logic            clk,
  input logic            resetn,
  cpu7_csr_irq_if.slave  bus
);
  localparam logic [CSR_BIT-1:0] A_CRMD   = CSR_BIT'(32'h0);
  localparam logic [CSR_BIT-1:0] A_PRMD   = CSR_BIT'(32'h1);
  localparam logic [CSR_BIT-1:0] A_ECFG   = CSR_BIT'(32'h4);
  localparam logic [CSR_BIT-1:0] A_ESTAT  = CSR_BIT'(32'h5);
  localparam logic [CSR_BIT-1:0] A_ERA    = CSR_BIT'(32'h6);
  localparam logic [CSR_BIT-1:0] A_BADV   = CSR_BIT'(32'h7);
  localparam logic [CSR_BIT-1:0] A_EENTRY = CSR_BIT'(32'hc);
  localparam logic [CSR_BIT-1:0] A_TCFG   = CSR_BIT'(32'h41);
  localparam logic [CSR_BIT-1:0] A_TVAL   = CSR_BIT'(32'h42);
  localparam logic [CSR_BIT-1:0] A_TICLR  = CSR_BIT'(32'h44);

  // Writable LIE bits: SWI[1:0], HWI lines starting at bit 2, TI at bit 11
  localparam logic [12:0] LIE_MASK = 13'h803 | (13'((1 << NHWI) - 1) << 2);

  logic [2:0]         crmd_q, crmd_d;
  logic [2:0]         prmd_q, prmd_d;
  logic [12:0]        ecfg_q, ecfg_d;
  logic [1:0]         swi_q, swi_d;
  logic [NHWI-1:0]    hwi_q;
  logic               ti_q, ti_d;
  logic [5:0]         ecode_q, ecode_d;
  logic [GRLEN-1:0]   era_q, era_d;
  logic [GRLEN-1:0]   badv_q, badv_d;
  logic [GRLEN-1:0]   eentry_q, eentry_d;
  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;

  logic [12:0]        is_vec;
  logic               evt;
  logic               ale_wins;
  logic [5:0]         evt_code;
  logic               fire;
  logic [TIMER_W-1:0] reload_val;

  // Assemble ESTAT.IS from its three sources
  always_comb begin
    is_vec = '0;
    is_vec[1:0] = swi_q;
    is_vec[2 +: NHWI] = hwi_q;
    is_vec[11] = ti_q;
  end

  assign bus.csr_int_req = crmd_q[2] & (|(is_vec & ecfg_q));
  assign bus.csr_era     = era_q;
  assign bus.csr_eentry  = eentry_q;

  // Combinational read port; reflects pre-edge state only
  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_raddr)
      A_CRMD:   bus.csr_rdata[2:0] = crmd_q;
      A_PRMD:   bus.csr_rdata[2:0] = prmd_q;
      A_ECFG:   bus.csr_rdata[12:0] = ecfg_q;
      A_ESTAT: begin
        bus.csr_rdata[12:0]  = is_vec;
        bus.csr_rdata[21:16] = ecode_q;
      end
      A_ERA:    bus.csr_rdata = era_q;
      A_BADV:   bus.csr_rdata = badv_q;
      A_EENTRY: bus.csr_rdata = eentry_q;
      A_TCFG:   bus.csr_rdata = GRLEN'(tcfg_q);
      A_TVAL:   bus.csr_rdata = GRLEN'(tval_q);
      default:  bus.csr_rdata = '0;
    endcase
  end

  // Exception priority encoder: int > illinst > syscall > brk > ale
  always_comb begin
    evt = bus.ecl_csr_int_e | bus.ecl_csr_illinst_e | bus.ecl_csr_syscall_e |
          bus.ecl_csr_brk_e | bus.ecl_csr_ale_e;
    ale_wins = 1'b0;
    if (bus.ecl_csr_int_e)          evt_code = 6'h00;
    else if (bus.ecl_csr_illinst_e) evt_code = 6'h0d;
    else if (bus.ecl_csr_syscall_e) evt_code = 6'h0b;
    else if (bus.ecl_csr_brk_e)     evt_code = 6'h0c;
    else begin
      evt_code = 6'h09;
      ale_wins = bus.ecl_csr_ale_e;
    end
  end

  // Next-state: CSR write first, then ertn, then events override the fields they own
  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    ecfg_d   = ecfg_q;
    swi_d    = swi_q;
    ecode_d  = ecode_q;
    era_d    = era_q;
    badv_d   = badv_q;
    eentry_d = eentry_q;
    tcfg_d   = tcfg_q;
    tval_d   = tval_q;
    ti_d     = ti_q;
    fire     = 1'b0;
    reload_val = {tcfg_q[TIMER_W-1:2], 2'b00};

    if (tcfg_q[0] && tval_q != '0) begin
      if (tval_q == TIMER_W'(1)) begin
        fire   = 1'b1;
        tval_d = tcfg_q[1] ? reload_val : '0;
      end else begin
        tval_d = tval_q - TIMER_W'(1);
      end
    end

    if (bus.csr_wen) begin
      case (bus.csr_waddr)
        A_CRMD:   crmd_d   = bus.csr_wdata[2:0];
        A_PRMD:   prmd_d   = bus.csr_wdata[2:0];
        A_ECFG:   ecfg_d   = bus.csr_wdata[12:0] & LIE_MASK;
        A_ESTAT:  swi_d    = bus.csr_wdata[1:0];
        A_ERA:    era_d    = bus.csr_wdata;
        A_BADV:   badv_d   = bus.csr_wdata;
        A_EENTRY: eentry_d = bus.csr_wdata;
        A_TCFG: begin
          tcfg_d = bus.csr_wdata[TIMER_W-1:0];
          tval_d = {bus.csr_wdata[TIMER_W-1:2], 2'b00};
        end
        A_TICLR:  if (bus.csr_wdata[0]) ti_d = 1'b0;
        default:  ;
      endcase
    end

    // A timer fire in the same cycle as TICLR keeps TI set
    if (fire) ti_d = 1'b1;

    if (bus.ecl_csr_ertn_e) crmd_d = prmd_q;

    if (evt) begin
      prmd_d  = crmd_q;
      crmd_d  = 3'b000;
      era_d   = bus.ifu_exu_pc_e;
      ecode_d = evt_code;
      if (ale_wins) badv_d = bus.ecl_csr_badv_e;
    end
  end

  // State registers; asynchronous reset clears everything including the timer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_q   <= '0;
      prmd_q   <= '0;
      ecfg_q   <= '0;
      swi_q    <= '0;
      hwi_q    <= '0;
      ti_q     <= 1'b0;
      ecode_q  <= '0;
      era_q    <= '0;
      badv_q   <= '0;
      eentry_q <= '0;
      tcfg_q   <= '0;
      tval_q   <= '0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      ecfg_q   <= ecfg_d;
      swi_q    <= swi_d;
      hwi_q    <= bus.hw_int;
      ti_q     <= ti_d;
      ecode_q  <= ecode_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
      tcfg_q   <= tcfg_d;
      tval_q   <= tval_d;
    end
  end
endmodule

// File: tb/tb_cpu7_csr_irq.sv
// tb/tb_cpu7_csr_irq.sv - scoreboard bench for cpu7_csr_irq
module tb_cpu7_csr_irq;
  logic clk;
  logic resetn;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  int          q_tag[$];
  int          q_kind[$];
  logic [31:0] q_exp[$];
  string       q_name[$];
  logic [31:0] mon_act;
  logic [31:0] mon_exp;
  int          mon_kind;
  string       mon_name;

  cpu7_csr_irq_if #(.GRLEN(32), .CSR_BIT(14), .NHWI(8)) bus ();

  cpu7_csr_irq #(.GRLEN(32), .CSR_BIT(14), .NHWI(8), .TIMER_W(32)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation tagged for the current cycle and compares
  always @(negedge clk) begin
    while (q_tag.size() != 0 && q_tag[0] <= cyc) begin
      void'(q_tag.pop_front());
      mon_kind = q_kind.pop_front();
      mon_exp  = q_exp.pop_front();
      mon_name = q_name.pop_front();
      case (mon_kind)
        0:       mon_act = bus.csr_rdata;
        1:       mon_act = {31'd0, bus.csr_int_req};
        2:       mon_act = bus.csr_era;
        default: mon_act = bus.csr_eentry;
      endcase
      checks++;
      if (mon_act !== mon_exp) begin
        failures++;
        $display("FAIL %s cycle=%0d actual=%h expected=%h", mon_name, cyc, mon_act, mon_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.csr_wen = 1'b0;
    bus.ecl_csr_int_e = 1'b0;
    bus.ecl_csr_illinst_e = 1'b0;
    bus.ecl_csr_syscall_e = 1'b0;
    bus.ecl_csr_brk_e = 1'b0;
    bus.ecl_csr_ale_e = 1'b0;
    bus.ecl_csr_ertn_e = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    bus.csr_wen = 1'b1;
    bus.csr_waddr = a;
    bus.csr_wdata = d;
  endtask

  task automatic expect_val(input int kind, input logic [31:0] e, input string nm);
    q_tag.push_back(cyc);
    q_kind.push_back(kind);
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  task automatic chk_rd(input logic [13:0] a, input logic [31:0] e, input string nm);
    bus.csr_raddr = a;
    expect_val(0, e, nm);
  endtask

  initial begin
    logic [13:0] addrs [10];
    logic [31:0] tv;
    logic [31:0] ti;
    addrs = '{14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'h7, 14'hc, 14'h41, 14'h42, 14'h44};
    resetn = 1'b0;
    bus.csr_raddr = '0; bus.csr_waddr = '0; bus.csr_wdata = '0; bus.csr_wen = 1'b0;
    bus.hw_int = '0; bus.ecl_csr_int_e = 1'b0; bus.ecl_csr_illinst_e = 1'b0;
    bus.ecl_csr_syscall_e = 1'b0; bus.ecl_csr_brk_e = 1'b0; bus.ecl_csr_ale_e = 1'b0;
    bus.ecl_csr_badv_e = '0; bus.ifu_exu_pc_e = '0; bus.ecl_csr_ertn_e = 1'b0;
    repeat (2) step();
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      chk_rd(addrs[i], 32'h0, $sformatf("reset_read_%0h", addrs[i]));
      expect_val(1, 32'h0, "reset_int_req");
      step();
    end
    expect_val(2, 32'h0, "reset_era_out");
    expect_val(3, 32'h0, "reset_eentry_out");

    // Hardware interrupt, take, ertn
    wr(14'h0, 32'h7); step();
    chk_rd(14'h0, 32'h7, "crmd_wr"); wr(14'h4, 32'h4); step();
    chk_rd(14'h4, 32'h4, "ecfg_wr"); expect_val(1, 32'h0, "int_req_before_hw"); bus.hw_int = 8'h01; step();
    bus.hw_int = 8'h00; chk_rd(14'h5, 32'h4, "estat_hwi"); expect_val(1, 32'h1, "int_req_hw");
    bus.ecl_csr_int_e = 1'b1; bus.ifu_exu_pc_e = 32'h1c000100; step();
    chk_rd(14'h6, 32'h1c000100, "era_int"); expect_val(2, 32'h1c000100, "era_out_int");
    expect_val(1, 32'h0, "int_req_after_take"); step();
    chk_rd(14'h1, 32'h7, "prmd_int"); step();
    chk_rd(14'h0, 32'h0, "crmd_int"); step();
    chk_rd(14'h5, 32'h0, "estat_ecode_int"); bus.ecl_csr_ertn_e = 1'b1; step();
    chk_rd(14'h0, 32'h7, "crmd_ertn");

    // Unmapped access, LIE mask, software interrupts
    wr(14'h3, 32'hffffffff); step();
    chk_rd(14'h3, 32'h0, "unmapped_read"); wr(14'h4, 32'hffffffff); step();
    chk_rd(14'h4, 32'h00000bff, "ecfg_mask"); wr(14'h5, 32'hffffffff); step();
    chk_rd(14'h5, 32'h3, "estat_swi"); expect_val(1, 32'h1, "int_req_swi"); wr(14'h5, 32'h0); step();
    expect_val(1, 32'h0, "int_req_swi_clr"); wr(14'h4, 32'h800); step();

    // Periodic timer, InitVal=2; TICLR coincides with the second fire
    wr(14'h41, 32'h0b); step();
    for (int i = 1; i <= 17; i++) begin
      tv = 32'(8 - ((i - 1) % 8));
      ti = (i == 9 || i == 10 || i == 17) ? 32'h1 : 32'h0;
      chk_rd(14'h42, tv, $sformatf("tval_periodic_%0d", i));
      expect_val(1, ti, $sformatf("ti_periodic_%0d", i));
      if (i == 10 || i == 16) wr(14'h44, 32'h1);
      step();
    end
    wr(14'h41, 32'h0); step();
    wr(14'h44, 32'h1); step();
    expect_val(1, 32'h0, "timer_off_ti"); chk_rd(14'h42, 32'h0, "timer_off_tval");

    // One-shot timer
    wr(14'h41, 32'h09); step();
    for (int i = 1; i <= 14; i++) begin
      tv = (i <= 8) ? 32'(9 - i) : 32'h0;
      ti = (i == 9 || i == 10) ? 32'h1 : 32'h0;
      chk_rd(14'h42, tv, $sformatf("tval_oneshot_%0d", i));
      expect_val(1, ti, $sformatf("ti_oneshot_%0d", i));
      if (i == 10) wr(14'h44, 32'h1);
      step();
    end

    // En=0 freezes the loaded value; InitVal=0 never fires
    wr(14'h41, 32'h0a); step();
    for (int i = 0; i < 3; i++) begin
      chk_rd(14'h42, 32'h8, "tval_frozen"); step();
    end
    chk_rd(14'h41, 32'h0a, "tcfg_read"); wr(14'h41, 32'h03); step();
    for (int i = 0; i < 6; i++) begin
      chk_rd(14'h42, 32'h0, "tval_init0"); expect_val(1, 32'h0, "ti_init0"); step();
    end

    // Asynchronous reset in the middle of a count
    wr(14'h41, 32'h0b); step(); step(); step();
    chk_rd(14'h42, 32'h6, "tval_pre_reset");
    #6 resetn = 1'b0;
    step();
    chk_rd(14'h42, 32'h0, "tval_in_reset");
    resetn = 1'b1; step();
    repeat (12) step();
    chk_rd(14'h5, 32'h0, "estat_after_reset"); step();
    chk_rd(14'h42, 32'h0, "tval_after_reset");

    // Exception priority and BADV capture
    bus.ecl_csr_illinst_e = 1'b1; bus.ecl_csr_ale_e = 1'b1;
    bus.ecl_csr_badv_e = 32'h1234; bus.ifu_exu_pc_e = 32'h1c000200; step();
    chk_rd(14'h5, 32'h000d0000, "ecode_ill_over_ale"); step();
    chk_rd(14'h7, 32'h0, "badv_unchanged"); expect_val(2, 32'h1c000200, "era_ill");
    bus.ecl_csr_ale_e = 1'b1; bus.ifu_exu_pc_e = 32'h1c000204; step();
    chk_rd(14'h5, 32'h00090000, "ecode_ale"); step();
    chk_rd(14'h7, 32'h1234, "badv_ale");
    bus.ecl_csr_syscall_e = 1'b1; bus.ecl_csr_brk_e = 1'b1; step();
    chk_rd(14'h5, 32'h000b0000, "ecode_sys_over_brk"); wr(14'h0, 32'h7); step();

    // CSR write collides with an event
    wr(14'h0, 32'h3); bus.ecl_csr_syscall_e = 1'b1; bus.ifu_exu_pc_e = 32'h1c000300; step();
    chk_rd(14'h0, 32'h0, "crmd_wr_vs_sys"); expect_val(2, 32'h1c000300, "era_sys"); step();
    chk_rd(14'h1, 32'h7, "prmd_sys"); step();
    chk_rd(14'h5, 32'h000b0000, "ecode_sys");
    wr(14'hc, 32'h1c008000); bus.ecl_csr_brk_e = 1'b1; step();
    chk_rd(14'hc, 32'h1c008000, "eentry_read"); expect_val(3, 32'h1c008000, "eentry_out"); step();
    chk_rd(14'h5, 32'h000c0000, "ecode_brk");

    // Ertn and event in the same cycle
    wr(14'h0, 32'h5); step();
    bus.ecl_csr_ertn_e = 1'b1; bus.ecl_csr_brk_e = 1'b1; step();
    chk_rd(14'h0, 32'h0, "crmd_ertn_vs_evt"); step();
    chk_rd(14'h1, 32'h5, "prmd_ertn_vs_evt"); step();

    step(); step();
    if (q_tag.size() != 0) begin
      $display("FAIL scoreboard_drain actual=%0d expected=0", q_tag.size());
      failures = failures + q_tag.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
